// File: rtl/fetch_stage_if.sv
// fetch_stage_if: IF-stage bus bundle (instruction memory, redirect, IF/ID handshake).
// The misalign_o flag exists only when FETCH_MISALIGN_EXC_EN is defined.
interface fetch_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] inst_o;
`ifdef FETCH_MISALIGN_EXC_EN
    logic            misalign_o;
`endif

    // Fetch stage side
    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output valid_o,
        input  ready_i,
        output pc_o,
        output inst_o
`ifdef FETCH_MISALIGN_EXC_EN
        , output misalign_o
`endif
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  valid_o,
        output ready_i,
        input  pc_o,
        input  inst_o
`ifdef FETCH_MISALIGN_EXC_EN
        , input misalign_o
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch. Owns the PC, drives a 1-cycle-latency
// instruction memory and presents {pc, inst} to decode via a valid/ready
// register backed by a 1-entry hold buffer. Redirects flush and restart fetch.
// Optional macro FETCH_MISALIGN_EXC_EN: misaligned redirect targets produce a
// single misalign exception entry and halt fetch until the next redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic           clk_i,
    input logic           rst_ni,
    fetch_stage_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(3);

    typedef enum logic {BOOT, RUN} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            inflight_q;
    logic            kill_q;
    logic            hold_v_q;
    logic [XLEN-1:0] hold_pc_q;
    logic [XLEN-1:0] hold_inst_q;
    logic            valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [XLEN-1:0] out_inst_q;
`ifdef FETCH_MISALIGN_EXC_EN
    logic            misalign_q;
    logic            halt_q;
`endif

    logic req;
    logic resp;
    logic drain;
    logic slot_free;
    logic halt;

    // Request decision and response/handshake qualifiers
    always_comb begin
        halt = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
        halt = halt_q;
`endif
        drain     = valid_q && bus.ready_i;
        slot_free = !valid_q || bus.ready_i;
        resp      = inflight_q && !kill_q;
        req       = (state_q == RUN) && !bus.redirect_i && !hold_v_q
                    && !(valid_q && !bus.ready_i && inflight_q) && !halt;
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_q;
    assign bus.valid_o     = valid_q;
    assign bus.pc_o        = out_pc_q;
    assign bus.inst_o      = out_inst_q;
`ifdef FETCH_MISALIGN_EXC_EN
    assign bus.misalign_o  = misalign_q;
`endif

    // PC, FSM, in-flight tracking, hold buffer and IF/ID output register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            kill_q      <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_pc_q   <= '0;
            hold_inst_q <= NOP_INST;
            valid_q     <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= NOP_INST;
`ifdef FETCH_MISALIGN_EXC_EN
            misalign_q  <= 1'b0;
            halt_q      <= 1'b0;
`endif
        end else begin
            if (state_q == BOOT) begin
                state_q <= RUN;
            end
            if (bus.redirect_i) begin
                // Redirect overrides any handshake or arriving response
                pc_q       <= bus.redirect_pc_i & ~LOW_MASK;
                kill_q     <= inflight_q;
                inflight_q <= 1'b0;
                hold_v_q   <= 1'b0;
                valid_q    <= 1'b0;
                out_inst_q <= NOP_INST;
`ifdef FETCH_MISALIGN_EXC_EN
                misalign_q <= 1'b0;
                halt_q     <= 1'b0;
                if (bus.redirect_pc_i[1:0] != 2'b00) begin
                    valid_q    <= 1'b1;
                    misalign_q <= 1'b1;
                    halt_q     <= 1'b1;
                    out_pc_q   <= bus.redirect_pc_i;
                end
`endif
            end else begin
                kill_q     <= 1'b0;
                inflight_q <= req;
                if (req) begin
                    pc_q     <= pc_q + PC_STEP;
                    req_pc_q <= pc_q;
                end
                if (resp) begin
                    if (slot_free && !hold_v_q) begin
                        valid_q    <= 1'b1;
                        out_pc_q   <= req_pc_q;
                        out_inst_q <= bus.imem_rdata_i;
                    end else if (slot_free) begin
                        out_pc_q    <= hold_pc_q;
                        out_inst_q  <= hold_inst_q;
                        hold_pc_q   <= req_pc_q;
                        hold_inst_q <= bus.imem_rdata_i;
                    end else begin
                        hold_v_q    <= 1'b1;
                        hold_pc_q   <= req_pc_q;
                        hold_inst_q <= bus.imem_rdata_i;
                    end
                end else if (drain) begin
                    if (hold_v_q) begin
                        hold_v_q   <= 1'b0;
                        out_pc_q   <= hold_pc_q;
                        out_inst_q <= hold_inst_q;
                    end else begin
                        valid_q    <= 1'b0;
                        out_inst_q <= NOP_INST;
`ifdef FETCH_MISALIGN_EXC_EN
                        misalign_q <= 1'b0;
`endif
                    end
                end
            end
        end
    end

    // The request rule keeps a response from ever meeting an occupied hold buffer
    hold_no_collision: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp && hold_v_q));

endmodule
